// File: rtl/cpu_core_param.sv
// rtl/cpu_core_param.sv - parametrised instruction-driven core with handshake, iterative divide and fault trapping
// Optional macro CRYPTO_EN enables the ENC/DEC key-XOR opcodes; otherwise they trap as illegal.
module cpu_core_param #(
  parameter int                DATA_W      = 19,
  parameter int                NUM_REGS    = 16,
  parameter int                STACK_DEPTH = 16,
  parameter int                DMEM_DEPTH  = 1024,
  parameter int                PC_W        = DATA_W - 5,
  parameter logic [DATA_W-1:0] KEY         = 19'h55555
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] result,
  output logic              busy,
  output logic              fault,
  output logic [1:0]        fault_code
);
  localparam int RIDX_W = $clog2(NUM_REGS);
  localparam int DA_W   = $clog2(DMEM_DEPTH);
  localparam int SP_W   = $clog2(STACK_DEPTH + 1);
  localparam int SI_W   = $clog2(STACK_DEPTH);
  localparam int CNT_W  = $clog2(DATA_W);

  localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_MUL = 5'b00010, OP_DIV = 5'b00011;
  localparam logic [4:0] OP_INC = 5'b00100, OP_DEC = 5'b00101, OP_AND = 5'b00110, OP_OR  = 5'b00111;
  localparam logic [4:0] OP_XOR = 5'b01000, OP_NOT = 5'b01001, OP_JMP = 5'b01010, OP_BEQ = 5'b01011;
  localparam logic [4:0] OP_BNE = 5'b01100, OP_CALL = 5'b01101, OP_RET = 5'b01110;
  localparam logic [4:0] OP_LOAD = 5'b01111, OP_STORE = 5'b10000;
`ifdef CRYPTO_EN
  localparam logic [4:0] OP_ENC = 5'b10001, OP_XDEC = 5'b10010;
`endif

  typedef enum logic [1:0] {S_RUN, S_DIV, S_FAULT} state_t;
  state_t state, state_n;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];
  logic [PC_W-1:0]   stack [STACK_DEPTH];
  logic [SP_W-1:0]   sp;

  logic [4:0]        opcode;
  logic [RIDX_W-1:0] r1, r2, r3;
  logic [PC_W-1:0]   imm_pc;
  logic [DA_W-1:0]   addr;
  logic [DATA_W-1:0] v1, v2, v3;
  logic [SI_W-1:0]   stk_top;

  assign opcode  = instr[DATA_W-1 -: 5];
  assign r1      = instr[DATA_W-6 -: RIDX_W];
  assign r2      = instr[DATA_W-6-RIDX_W -: RIDX_W];
  assign r3      = instr[DATA_W-6-2*RIDX_W -: RIDX_W];
  assign imm_pc  = PC_W'(instr[DATA_W-6:0]);
  assign addr    = instr[DA_W-1:0];
  assign v1      = regs[r1];
  assign v2      = regs[r2];
  assign v3      = regs[r3];
  // Low-bit decrement also gives the right slot when sp == STACK_DEPTH
  assign stk_top = sp[SI_W-1:0] - SI_W'(1);

  logic illegal, trap, accept;
  logic [1:0] trap_code;
`ifdef CRYPTO_EN
  assign illegal = opcode > OP_XDEC;
`else
  assign illegal = opcode > OP_STORE;
`endif

  always_comb begin
    trap = 1'b0;
    trap_code = 2'd0;
    if (illegal) begin
      trap = 1'b1;
      trap_code = 2'd3;
    end else if (opcode == OP_CALL && sp == SP_W'(STACK_DEPTH)) begin
      trap = 1'b1;
      trap_code = 2'd1;
    end else if (opcode == OP_RET && sp == '0) begin
      trap = 1'b1;
      trap_code = 2'd2;
    end
  end

  // Restoring divider: dividend shifts out of quo_q as quotient bits shift in
  logic [DATA_W-1:0] quo_q, dsr_q, rem_q, quo_n;
  logic [DATA_W:0]   rem_sh, rem_diff;
  logic [CNT_W-1:0]  div_cnt;
  logic [RIDX_W-1:0] div_dst;
  logic              div_last;

  assign rem_sh   = {rem_q, quo_q[DATA_W-1]};
  assign rem_diff = rem_sh - {1'b0, dsr_q};
  assign quo_n    = {quo_q[DATA_W-2:0], ~rem_diff[DATA_W]};
  assign div_last = div_cnt == CNT_W'(DATA_W - 1);

  always_comb begin
    state_n = state;
    instr_ready = 1'b0;
    busy = 1'b0;
    case (state)
      S_RUN: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          if (trap) state_n = S_FAULT;
          else if (opcode == OP_DIV) state_n = S_DIV;
        end
      end
      S_DIV: begin
        busy = 1'b1;
        if (div_last) state_n = S_RUN;
      end
      default: ;
    endcase
  end

  assign accept = instr_valid & instr_ready;
  assign fault  = state == S_FAULT;

  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_n;
  end

  logic              wr_en;
  logic [DATA_W-1:0] wr_val;
  logic [PC_W-1:0]   pc_n;

  always_comb begin
    wr_en  = 1'b0;
    wr_val = '0;
    pc_n   = pc + PC_W'(1);
    case (opcode)
      OP_ADD:  begin wr_en = 1'b1; wr_val = v2 + v3; end
      OP_SUB:  begin wr_en = 1'b1; wr_val = v2 - v3; end
      OP_MUL:  begin wr_en = 1'b1; wr_val = v2 * v3; end
      OP_INC:  begin wr_en = 1'b1; wr_val = v1 + DATA_W'(1); end
      OP_DEC:  begin wr_en = 1'b1; wr_val = v1 - DATA_W'(1); end
      OP_AND:  begin wr_en = 1'b1; wr_val = v2 & v3; end
      OP_OR:   begin wr_en = 1'b1; wr_val = v2 | v3; end
      OP_XOR:  begin wr_en = 1'b1; wr_val = v2 ^ v3; end
      OP_NOT:  begin wr_en = 1'b1; wr_val = ~v2; end
      OP_JMP:  pc_n = imm_pc;
      OP_BEQ:  if (v1 == v2) pc_n = imm_pc;
      OP_BNE:  if (v1 != v2) pc_n = imm_pc;
      OP_CALL: pc_n = imm_pc;
      OP_RET:  pc_n = stack[stk_top];
      OP_LOAD: begin wr_en = 1'b1; wr_val = dmem[addr]; end
`ifdef CRYPTO_EN
      OP_ENC, OP_XDEC: begin wr_en = 1'b1; wr_val = v2 ^ KEY; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      sp <= '0;
      result <= '0;
      fault_code <= 2'd0;
      div_cnt <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      result <= regs[0];
      if (accept) begin
        if (trap) begin
          fault_code <= trap_code;
        end else if (opcode == OP_DIV) begin
          div_dst <= r1;
          quo_q   <= v2;
          dsr_q   <= v3;
          rem_q   <= '0;
          div_cnt <= '0;
        end else begin
          pc <= pc_n;
          if (wr_en) regs[r1] <= wr_val;
          if (opcode == OP_CALL)     sp <= sp + SP_W'(1);
          else if (opcode == OP_RET) sp <= sp - SP_W'(1);
        end
      end
      if (busy) begin
        quo_q   <= quo_n;
        rem_q   <= rem_diff[DATA_W] ? rem_sh[DATA_W-1:0] : rem_diff[DATA_W-1:0];
        div_cnt <= div_cnt + CNT_W'(1);
        if (div_last) begin
          regs[div_dst] <= quo_n;
          pc <= pc + PC_W'(1);
        end
      end
    end
  end

  // Data memory and return stack are deliberately left uninitialised by reset
  always_ff @(posedge clk) begin
    if (!rst && accept && !trap) begin
      if (opcode == OP_STORE) dmem[addr] <= v1;
      if (opcode == OP_CALL)  stack[sp[SI_W-1:0]] <= pc + PC_W'(1);
    end
  end
endmodule

// File: tb/tb_cpu_core_param.sv
// tb/tb_cpu_core_param.sv - self-checking bench for cpu_core_param against an ISA-level model
module tb_cpu_core_param;
  localparam logic [18:0] KEY = 19'h55555;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [18:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready, busy, fault;
  logic [13:0] pc;
  logic [18:0] result;
  logic [1:0]  fault_code;

  always #5 clk = ~clk;

  cpu_core_param dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .result(result), .busy(busy),
    .fault(fault), .fault_code(fault_code)
  );

  int checks = 0;
  int failures = 0;

  logic [18:0] m_regs [16];
  logic [18:0] m_dmem [1024];
  logic [13:0] m_stack [16];
  int          m_sp;
  logic [13:0] m_pc;
  logic        m_fault;
  logic [1:0]  m_code;
  logic [18:0] m_result;

  typedef struct {
    int          op, a, b, c;
    logic [18:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] mk(input int op, input int a, input int b, input int c);
    return {5'(op), 4'(a), 4'(b), 4'(c), 2'b00};
  endfunction

  function automatic logic [18:0] mk_imm(input int op, input int imm);
    return {5'(op), 14'(imm)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_sp = 0; m_pc = '0; m_fault = 1'b0; m_code = 2'd0; m_result = '0;
  endtask

  task automatic check_all();
    chk("pc", 32'(pc), 32'(m_pc));
    chk("result", 32'(result), 32'(m_result));
    chk("fault", 32'(fault), 32'(m_fault));
    chk("fault_code", 32'(fault_code), 32'(m_code));
    chk("ready", 32'(instr_ready), 32'(!m_fault));
    chk("busy", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; instr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic tick();
    @(posedge clk);
    m_result = m_regs[0];
    #1;
  endtask

  // ISA-level effect of one accepted instruction
  task automatic model_exec(input logic [18:0] ins, output bit is_div,
                            output logic [18:0] q, output int dst);
    int op, a, b, c;
    logic [13:0] imm, npc;
    logic [18:0] x, y, z;
    op = int'(ins[18:14]); a = int'(ins[13:10]); b = int'(ins[9:6]); c = int'(ins[5:2]);
    imm = ins[13:0];
    x = m_regs[a]; y = m_regs[b]; z = m_regs[c];
    npc = m_pc + 14'd1;
    is_div = 1'b0; q = '0; dst = a;
    case (op)
      0: m_regs[a] = y + z;
      1: m_regs[a] = y - z;
      2: m_regs[a] = y * z;
      3: begin is_div = 1'b1; q = (z == 0) ? 19'h7FFFF : y / z; return; end
      4: m_regs[a] = x + 19'd1;
      5: m_regs[a] = x - 19'd1;
      6: m_regs[a] = y & z;
      7: m_regs[a] = y | z;
      8: m_regs[a] = y ^ z;
      9: m_regs[a] = ~y;
      10: npc = imm;
      11: if (x == y) npc = imm;
      12: if (x != y) npc = imm;
      13: begin
        if (m_sp == 16) begin m_fault = 1'b1; m_code = 2'd1; return; end
        m_stack[m_sp] = npc; m_sp++; npc = imm;
      end
      14: begin
        if (m_sp == 0) begin m_fault = 1'b1; m_code = 2'd2; return; end
        m_sp--; npc = m_stack[m_sp];
      end
      15: m_regs[a] = m_dmem[imm[9:0]];
      16: m_dmem[imm[9:0]] = x;
`ifdef CRYPTO_EN
      17, 18: m_regs[a] = y ^ KEY;
`endif
      default: begin m_fault = 1'b1; m_code = 2'd3; return; end
    endcase
    m_pc = npc;
  endtask

  task automatic issue(input logic [18:0] ins);
    bit dv;
    logic [18:0] q;
    int dst;
    dv = 1'b0; q = '0; dst = 0;
    instr = ins; instr_valid = 1'b1;
    chk("ready_pre", 32'(instr_ready), 32'(!m_fault));
    @(posedge clk);
    m_result = m_regs[0];
    if (!m_fault) model_exec(ins, dv, q, dst);
    #1;
    instr_valid = 1'b0;
    if (dv) begin
      for (int k = 1; k <= 19; k++) begin
        chk("div_ready", 32'(instr_ready), 32'd0);
        chk("div_busy", 32'(busy), 32'd1);
        @(posedge clk);
        m_result = m_regs[0];
        if (k == 19) begin m_regs[dst] = q; m_pc = m_pc + 14'd1; end
        #1;
      end
    end
    check_all();
  endtask

  task automatic peek(input string name, input int r, input logic [18:0] exp);
    issue(mk(7, 0, r, r));
    tick();
    chk(name, 32'(result), 32'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[10];
    int safe_ops[9] = '{0, 1, 2, 4, 5, 6, 7, 8, 9};
    int pc0;

    model_reset();
    @(posedge clk); #1;
    do_reset();
    check_all();

    repeat (3) issue(mk(4, 1, 0, 0));
    issue(mk(0, 0, 1, 1));
    chk("add_pc", 32'(pc), 32'd4);
    tick();
    chk("add_result", 32'(result), 32'd6);

    // reg1 = 3, reg2 = all ones; each row writes reg0
    issue(mk(5, 2, 0, 0));
    vt[0] = '{0, 0, 1, 2, 19'h00002};
    vt[1] = '{1, 0, 1, 2, 19'h00004};
    vt[2] = '{2, 0, 1, 2, 19'h7FFFD};
    vt[3] = '{6, 0, 1, 2, 19'h00003};
    vt[4] = '{7, 0, 1, 2, 19'h7FFFF};
    vt[5] = '{8, 0, 1, 2, 19'h7FFFC};
    vt[6] = '{9, 0, 2, 0, 19'h00000};
    vt[7] = '{9, 0, 1, 0, 19'h7FFFC};
    vt[8] = '{4, 0, 0, 0, 19'h7FFFD};
    vt[9] = '{1, 0, 2, 1, 19'h7FFFC};
    foreach (vt[i]) begin
      issue(mk(vt[i].op, vt[i].a, vt[i].b, vt[i].c));
      tick();
      chk($sformatf("vec%0d", i), 32'(result), 32'(vt[i].exp));
    end

    do_reset();
    repeat (100) issue(mk(4, 2, 0, 0));
    repeat (7) issue(mk(4, 3, 0, 0));
    issue(mk(3, 4, 2, 3));
    chk("div_pc", 32'(pc), 32'd108);
    peek("div_q", 4, 19'd14);
    issue(mk(3, 4, 2, 8));
    chk("div0_fault", 32'(fault), 32'd0);
    peek("div0_q", 4, 19'h7FFFF);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      issue(mk_imm(13, 5));
      chk("call_pc", 32'(pc), 32'd5);
    end
    issue(mk_imm(13, 5));
    chk("ovf_fault", 32'(fault), 32'd1);
    chk("ovf_code", 32'(fault_code), 32'd1);
    issue(mk(4, 0, 0, 0));
    repeat (3) tick();
    check_all();

    do_reset();
    issue(mk_imm(14, 0));
    chk("unf_code", 32'(fault_code), 32'd2);
    do_reset();
    issue(mk_imm(10, 3));
    issue(mk_imm(13, 9));
    chk("call9_pc", 32'(pc), 32'd9);
    issue(mk_imm(14, 0));
    chk("ret_pc", 32'(pc), 32'd4);

    do_reset();
    repeat (3) issue(mk(4, 1, 0, 0));
    issue(mk_imm(16, 1025));
    issue(mk_imm(15, 14'h1401));
    peek("load_r5", 5, 19'd3);
    issue(mk_imm(11, 20));
    chk("beq_pc", 32'(pc), 32'd20);
    issue(mk_imm(12, 14'h0440));
    chk("bne_pc", 32'(pc), 32'd21);

    do_reset();
`ifdef CRYPTO_EN
    issue(mk(17, 6, 2, 0));
    issue(mk(18, 7, 6, 0));
    peek("enc_r6", 6, KEY);
    peek("dec_r7", 7, 19'd0);
`else
    issue(mk(17, 6, 2, 0));
    chk("enc_illegal", 32'(fault_code), 32'd3);
`endif
    do_reset();
    issue(mk(19, 1, 2, 3));
    chk("illegal_code", 32'(fault_code), 32'd3);

    // reset during an in-flight divide
    do_reset();
    issue(mk(4, 0, 0, 0));
    issue(mk(4, 2, 0, 0));
    instr = mk(3, 0, 2, 2); instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("middiv_busy", 32'(busy), 32'd1);
    repeat (5) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_code", 32'(fault_code), 32'd0);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    model_reset();
    tick();
    check_all();

    // randomized legal instruction stream
    do_reset();
    for (int i = 0; i < 8; i++) begin
      issue(mk(4, 1, 0, 0));
      issue(mk_imm(16, 1024 + i));
    end
    for (int n = 0; n < 300; n++) begin
      int s, a;
      s = int'($urandom_range(0, 99));
      a = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, 15));
      if (s < 5)
        issue(mk(3, a, int'($urandom_range(0, 15)), int'($urandom_range(0, 15))));
      else if (s < 15)
        issue(mk_imm(10 + int'($urandom_range(0, 2)), int'($urandom_range(0, 16383))));
      else if (s < 20)
        issue(mk_imm(16, int'($urandom_range(0, 15)) * 1024 + int'($urandom_range(0, 7))));
      else if (s < 25)
        issue(mk_imm(15, a * 1024 + int'($urandom_range(0, 7))));
      else
        issue(mk(safe_ops[$urandom_range(0, 8)], a,
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15))));
    end
    pc0 = int'(m_pc);
    tick();
    check_all();
    chk("rand_pc_hold", 32'(pc), 32'(pc0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
